bus8_reg_bank: RTL
==================

// Module: bus8_reg_bank
// PURPOSE
//  Parametrised 8-bit bus register bank: NUM_REGS registers behind one bus chip-select.
//  Each register is individually configured as one of:
//   - read/write control
//   - read-only status
//   - sticky write-1-to-clear (W1C) event
//  Per-register write and read strobes let user logic react to bus accesses.
//  Sits between the bus decoder and user logic; one instance per peripheral.
// PARAMETERS
//  NUM_REGS    8        number of registers, 1..2**ADDR_W
//  ADDR_W      3        width of i_Bus_Addr8
//  INIT_VALUES 0        [8*NUM_REGS-1:0]; reset value of reg n = INIT_VALUES[8n+7:8n]
//  RW_MASK     all 1s   [NUM_REGS-1:0]; 1 = read/write control reg, 0 = read-only (reads i_Reg_In)
//  W1C_MASK    0        [NUM_REGS-1:0]; 1 = sticky W1C event reg; overrides RW_MASK
// PORTS
//  i_Bus_Clk       in   1            bus clock
//  i_Bus_Rst_L     in   1            async reset, active low
//  i_Bus_CS        in   1            access strobe, one cycle per access
//  i_Bus_Wr_Rd_n   in   1            1 = write, 0 = read
//  i_Bus_Addr8     in   ADDR_W       register index
//  i_Bus_Wr_Data   in   8            write data
//  o_Bus_Rd_Data   out  8            read data
//  o_Bus_Rd_DV     out  1            read data valid, one-cycle pulse
//  i_Reg_In        in   8*NUM_REGS   RO: status value; W1C: per-bit event set inputs
//  o_Reg_Out       out  8*NUM_REGS   current stored value of every register
//  o_Reg_Wr_Pulse  out  NUM_REGS     1-cycle pulse: register n written
//  o_Reg_Rd_Pulse  out  NUM_REGS     1-cycle pulse: register n read
// BEHAVIOUR
//  - Clock/reset: single clock i_Bus_Clk; reset asynchronous, active low (i_Bus_Rst_L).
//  - Reset values:
//     o_Bus_Rd_Data = 0x00, o_Bus_Rd_DV = 0, o_Reg_Wr_Pulse = 0, o_Reg_Rd_Pulse = 0.
//     Stored reg n = INIT_VALUES slice n (RO regs store 0x00).
//  - Access is taken on any cycle with i_Bus_CS = 1; back-to-back accesses are legal.
//  - Write (CS=1, Wr_Rd_n=1, addr n < NUM_REGS):
//     RW reg: next cycle stored = wr_data.
//     RO reg: stored value unchanged.
//     W1C reg: stored &= ~wr_data.
//     o_Reg_Wr_Pulse[n] = 1 in the next cycle for all three types.
//  - Read (CS=1, Wr_Rd_n=0), 1-cycle latency; next cycle o_Bus_Rd_DV = 1 and:
//     RW/W1C reg: o_Bus_Rd_Data = stored value.
//     RO reg: o_Bus_Rd_Data = i_Reg_In slice, sampled at the CS cycle.
//     o_Reg_Rd_Pulse[n] = 1 in the same cycle as o_Bus_Rd_DV.
//  - o_Bus_Rd_Data holds its last value when DV = 0.
//  - W1C set: every cycle stored |= i_Reg_In slice.
//     Same bit set and cleared in one cycle: set wins (event never lost).
//  - RO regs: o_Reg_Out slice = 0x00.
//  - Out-of-range address (n >= NUM_REGS):
//     write ignored, no pulse.
//     read returns 0x00 with DV = 1, no rd pulse.
//  - All pulses are single-cycle and deassert automatically.
//     CS held high for k cycles = k accesses.
//  - Reset asserted mid-access: all outputs return to reset values immediately.
//     The pending read DV is dropped.
// TESTING
//  1 Reset, NUM_REGS=8, INIT_VALUES[15:8]=0xA5 -> o_Reg_Out reg1 = 0xA5, DV = 0, all pulses 0.
//  2 Write 0x3C to addr 2 (RW), then read addr 2
//     -> Wr_Pulse[2] 1 cycle after the write.
//     -> DV 1 cycle after the read CS with data 0x3C, Rd_Pulse[2] in the same cycle.
//  3 Reg 4 RO, i_Reg_In slice = 0x5A, write 0xFF then read
//     -> read data 0x5A, o_Reg_Out slice unchanged at 0x00, Wr_Pulse[4] still fires.
//  4 Reg 5 W1C: pulse i_Reg_In bits 0 and 3 -> reads 0x09.
//     Write 0x01 -> reads 0x08.
//     Write 0x08 while bit 3 set input high -> bit 3 remains 1.
//  5 Read addr 7 with NUM_REGS=6 -> DV = 1, data 0x00, no Rd_Pulse.
//     Write to addr 7 -> no state change, no pulse.
//  6 Back-to-back reads of addr 0,1,2 with CS held 3 cycles -> 3 consecutive DV cycles with matching data.
//     Drop i_Bus_Rst_L in the second of those cycles -> DV and data go to 0 asynchronously.

Source files
------------

// File: rtl/bus8_reg_bank.sv
// bus8_reg_bank: parametrised bank of 8-bit RW / RO / W1C registers behind one
// bus chip-select, with per-register write/read strobes towards user logic.
module bus8_reg_bank #(
  parameter int                    NUM_REGS    = 8,
  parameter int                    ADDR_W      = 3,
  parameter logic [8*NUM_REGS-1:0] INIT_VALUES = '0,
  parameter logic [NUM_REGS-1:0]   RW_MASK     = '1,
  parameter logic [NUM_REGS-1:0]   W1C_MASK    = '0
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  input  logic                  i_Bus_CS,
  input  logic                  i_Bus_Wr_Rd_n,
  input  logic [ADDR_W-1:0]     i_Bus_Addr8,
  input  logic [7:0]            i_Bus_Wr_Data,
  output logic [7:0]            o_Bus_Rd_Data,
  output logic                  o_Bus_Rd_DV,
  input  logic [8*NUM_REGS-1:0] i_Reg_In,
  output logic [8*NUM_REGS-1:0] o_Reg_Out,
  output logic [NUM_REGS-1:0]   o_Reg_Wr_Pulse,
  output logic [NUM_REGS-1:0]   o_Reg_Rd_Pulse
);

  logic                  wr_access;
  logic                  rd_access;
  logic [NUM_REGS-1:0]   addr_hit;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]   rd_hit;
  logic [8*NUM_REGS-1:0] stored_flat;
  logic [8*NUM_REGS-1:0] rd_view_flat;
  logic [7:0]            rd_mux;

  logic [7:0]            rd_data_reg;
  logic                  rd_dv_reg;
  logic [NUM_REGS-1:0]   wr_pulse_reg;
  logic [NUM_REGS-1:0]   rd_pulse_reg;

  assign wr_access = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_access = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  // Only indices below NUM_REGS decode, so out-of-range accesses hit nothing.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign addr_hit[gi] = (i_Bus_Addr8 == ADDR_W'(gi));
      assign wr_hit[gi]   = wr_access & addr_hit[gi];
      assign rd_hit[gi]   = rd_access & addr_hit[gi];

      if (W1C_MASK[gi]) begin : g_w1c
        logic [7:0] value_reg;
        logic [7:0] clr_bits;

        assign clr_bits = wr_hit[gi] ? i_Bus_Wr_Data : 8'h00;

        // Set is OR-ed in after the clear so a coincident event is never lost.
        always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
          if (!i_Bus_Rst_L) begin
            value_reg <= INIT_VALUES[8*gi +: 8];
          end else begin
            value_reg <= (value_reg & ~clr_bits) | i_Reg_In[8*gi +: 8];
          end
        end

        assign stored_flat[8*gi +: 8]  = value_reg;
        assign rd_view_flat[8*gi +: 8] = value_reg;
      end else if (RW_MASK[gi]) begin : g_rw
        logic [7:0] value_reg;
        logic       unused_in;

        always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
          if (!i_Bus_Rst_L) begin
            value_reg <= INIT_VALUES[8*gi +: 8];
          end else if (wr_hit[gi]) begin
            value_reg <= i_Bus_Wr_Data;
          end
        end

        assign unused_in               = ^i_Reg_In[8*gi +: 8];
        assign stored_flat[8*gi +: 8]  = value_reg;
        assign rd_view_flat[8*gi +: 8] = value_reg;
      end else begin : g_ro
        // Status register: nothing stored, reads go straight to user logic.
        assign stored_flat[8*gi +: 8]  = 8'h00;
        assign rd_view_flat[8*gi +: 8] = i_Reg_In[8*gi +: 8];
      end
    end
  endgenerate

  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_hit[i]) begin
        rd_mux = rd_mux | rd_view_flat[8*i +: 8];
      end
    end
  end

  // Read data only updates on a read so it holds between accesses.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      rd_data_reg  <= 8'h00;
      rd_dv_reg    <= 1'b0;
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
    end else begin
      rd_dv_reg    <= rd_access;
      wr_pulse_reg <= wr_hit;
      rd_pulse_reg <= rd_hit;
      if (rd_access) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  assign o_Bus_Rd_Data  = rd_data_reg;
  assign o_Bus_Rd_DV    = rd_dv_reg;
  assign o_Reg_Wr_Pulse = wr_pulse_reg;
  assign o_Reg_Rd_Pulse = rd_pulse_reg;
  assign o_Reg_Out      = stored_flat;

endmodule
